// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and widths for the data-memory arbiter
package rv32i_pkg;
   typedef enum logic {PRI_M0, FORCE_M1} arb_state_t;
   typedef enum logic {OWN_M0, OWN_M1} rd_owner_t;
   localparam int DMEM_ADDR_W = 30;
endpackage

// File: rtl/rv32i_dmem_starve_ctr.sv
// rv32i_dmem_starve_ctr: counts consecutive denied M1 cycles and requests a forced M1 grant
module rv32i_dmem_starve_ctr
   import rv32i_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic m1_req,
   input  logic m1_gnt,
   output logic force_m1
);
   logic [3:0] wait_cnt;
   always_ff @(posedge clk or negedge reset)
      if (!reset) wait_cnt <= '0;
      else if (!m1_req || m1_gnt) wait_cnt <= '0;
      else if (wait_cnt != 4'hf) wait_cnt <= wait_cnt + 4'd1;
   assign force_m1 = m1_req && !m1_gnt && wait_cnt == 4'(STARVE_LIMIT - 1);
endmodule

// File: rtl/rv32i_dmem_arbiter.sv
// rv32i_dmem_arbiter: shares the RAM data port between the memory stage (M0) and the loader (M1)
module rv32i_dmem_arbiter
   import rv32i_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = DMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [3:0]        m0_be,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [3:0]        m1_be,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   output logic              memif_we,
   output logic [3:0]        memif_be,
   output logic [ADDR_W-1:0] memif_addr,
   output logic [31:0]       memif_wdata,
   input  logic [31:0]       memif_rdata
);
   arb_state_t state;
   rd_owner_t  rd_owner;
   logic       rd_pend;
   logic       force_m1;
   logic       g0;
   logic       g1;
   // raw grants feed state; only the outputs are masked while reset is held
   assign g1 = m1_req && (state == FORCE_M1 || !m0_req);
   assign g0 = m0_req && !g1;
   assign m0_gnt = reset && g0;
   assign m1_gnt = reset && g1;
   assign memif_we    = m0_gnt ? m0_we : m1_gnt && m1_we;
   assign memif_be    = m0_gnt ? m0_be : m1_gnt ? m1_be : 4'h0;
   assign memif_addr  = m1_gnt ? m1_addr : m0_addr;
   assign memif_wdata = m1_gnt ? m1_wdata : m0_wdata;
   assign m0_rvalid = rd_pend && rd_owner == OWN_M0;
   assign m1_rvalid = rd_pend && rd_owner == OWN_M1;
   assign m0_rdata  = memif_rdata;
   assign m1_rdata  = memif_rdata;
   rv32i_dmem_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .reset    (reset),
      .m1_req   (m1_req),
      .m1_gnt   (g1),
      .force_m1 (force_m1)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= PRI_M0;
         rd_pend  <= 1'b0;
         rd_owner <= OWN_M0;
      end else begin
         state    <= (state == PRI_M0 && force_m1) ? FORCE_M1 : PRI_M0;
         rd_pend  <= (g0 && !m0_we) || (g1 && !m1_we);
         rd_owner <= g1 ? OWN_M1 : OWN_M0;
      end
endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// tb_rv32i_dmem_arbiter: directed scenarios plus randomized traffic against a priority/starvation model
module tb_rv32i_dmem_arbiter;
   localparam int LIMIT = 4;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [3:0] m0_be = 4'h0, m1_be = 4'h0;
   logic [29:0] m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, memif_we;
   logic [31:0] m0_rdata, m1_rdata, memif_wdata, memif_rdata;
   logic [3:0] memif_be;
   logic [29:0] memif_addr;
   int checks = 0;
   int errs = 0;
   logic [31:0] ram [256];
   logic [31:0] ref_mem [256];
   logic [31:0] ram_merged;

   always #5 clk = ~clk;

   rv32i_dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(30)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .memif_we(memif_we), .memif_be(memif_be), .memif_addr(memif_addr),
      .memif_wdata(memif_wdata), .memif_rdata(memif_rdata)
   );

   // write-first synchronous RAM standing in for syncDualPortRam
   always_comb begin
      ram_merged = ram[memif_addr[7:0]];
      for (int b = 0; b < 4; b++)
         if (memif_we && memif_be[b]) ram_merged[8*b +: 8] = memif_wdata[8*b +: 8];
   end
   always @(posedge clk) begin
      if (memif_we) ram[memif_addr[7:0]] <= ram_merged;
      memif_rdata <= ram_merged;
   end

   task automatic idle_inputs;
      m0_req = 1'b0; m0_we = 1'b0; m0_be = 4'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0;
   endtask

   task automatic do_reset;
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset;
      m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'hf;
      m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hf;
      @(negedge clk); #1;
      checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errs++; $display("FAIL reset_gnt got=%b%b exp=00", m0_gnt, m1_gnt); end
      checks++; if (memif_we !== 1'b0 || memif_be !== 4'h0) begin errs++; $display("FAIL reset_memif we=%b be=%h exp=0/0", memif_we, memif_be); end
      checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errs++; $display("FAIL reset_rvalid got=%b%b exp=00", m0_rvalid, m1_rvalid); end
      reset = 1'b1;
      #1;
      checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errs++; $display("FAIL reset_release_gnt got=%b%b exp=10", m0_gnt, m1_gnt); end
      #1 idle_inputs();
   endtask

   task automatic test_m0_read;
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h10;
      #1;
      checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errs++; $display("FAIL m0rd_gnt got=%b%b exp=10", m0_gnt, m1_gnt); end
      checks++; if (memif_addr !== 30'h10 || memif_we !== 1'b0) begin errs++; $display("FAIL m0rd_memif addr=%h we=%b exp=10/0", memif_addr, memif_we); end
      @(posedge clk); #1;
      checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin errs++; $display("FAIL m0rd_rvalid got=%b%b exp=10", m0_rvalid, m1_rvalid); end
      checks++; if (m0_rdata !== ref_mem[8'h10]) begin errs++; $display("FAIL m0rd_data got=%h exp=%h", m0_rdata, ref_mem[8'h10]); end
      @(negedge clk) idle_inputs();
   endtask

   task automatic test_starvation;
      logic exp1;
      do_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h1;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 30'h2;
      for (int i = 0; i < 10; i++) begin
         #1;
         exp1 = (i % 5) == 4;
         checks++; if (m0_gnt !== !exp1 || m1_gnt !== exp1) begin errs++; $display("FAIL starve_cycle%0d got=%b%b exp=%b%b", i, m0_gnt, m1_gnt, !exp1, exp1); end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_write_read;
      @(negedge clk);
      m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hf; m1_addr = 30'h20; m1_wdata = 32'hdeadbeef;
      #1;
      checks++; if (m1_gnt !== 1'b1 || memif_we !== 1'b1) begin errs++; $display("FAIL wr_gnt gnt=%b we=%b exp=1/1", m1_gnt, memif_we); end
      ref_mem[8'h20] = 32'hdeadbeef;
      @(negedge clk);
      idle_inputs();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h20;
      @(posedge clk); #1;
      checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hdeadbeef) begin errs++; $display("FAIL raw_data rvalid=%b got=%h exp=deadbeef", m0_rvalid, m0_rdata); end
      checks++; if (m1_rvalid !== 1'b0) begin errs++; $display("FAIL raw_m1_rvalid got=%b exp=0", m1_rvalid); end
      @(negedge clk) idle_inputs();
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h5;
      @(negedge clk);
      checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== ref_mem[5]) begin errs++; $display("FAIL b2b_first rv=%b%b data=%h exp=10/%h", m0_rvalid, m1_rvalid, m0_rdata, ref_mem[5]); end
      m0_req = 1'b0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 30'h6;
      #1;
      checks++; if (m1_gnt !== 1'b1) begin errs++; $display("FAIL b2b_m1_gnt got=%b exp=1", m1_gnt); end
      @(posedge clk); #1;
      checks++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== ref_mem[6]) begin errs++; $display("FAIL b2b_second rv=%b%b data=%h exp=01/%h", m0_rvalid, m1_rvalid, m1_rdata, ref_mem[6]); end
      @(negedge clk) idle_inputs();
   endtask

   task automatic test_reset_mid_read;
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h7;
      #1;
      checks++; if (m0_gnt !== 1'b1) begin errs++; $display("FAIL midrst_gnt got=%b exp=1", m0_gnt); end
      #1 reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (m0_rvalid !== 1'b0) begin errs++; $display("FAIL midrst_during got=%b exp=0", m0_rvalid); end
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errs++; $display("FAIL midrst_after got=%b%b exp=00", m0_rvalid, m1_rvalid); end
   endtask

   task automatic test_random;
      int d, wait_obs, max_wait;
      logic p1, e0, e1, erv0, erv1, ewe;
      logic [31:0] erd;
      logic [7:0] a;
      do_reset();
      d = 0; wait_obs = 0; max_wait = 0; p1 = 1'b0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         m0_req = 1'($urandom_range(0, 1)); m0_we = 1'($urandom); m0_be = 4'($urandom);
         m0_addr = {22'b0, 8'($urandom)}; m0_wdata = $urandom;
         if (!p1 && $urandom_range(0, 2) != 0) begin
            p1 = 1'b1; m1_we = 1'($urandom); m1_be = 4'($urandom);
            m1_addr = {22'b0, 8'($urandom)}; m1_wdata = $urandom;
         end
         m1_req = p1;
         #1;
         e1 = m1_req && (!m0_req || d >= LIMIT);
         e0 = m0_req && !e1;
         ewe = (e0 && m0_we) || (e1 && m1_we);
         checks++; if (m0_gnt !== e0 || m1_gnt !== e1) begin errs++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", n, m0_gnt, m1_gnt, e0, e1); end
         checks++; if (memif_we !== ewe) begin errs++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", n, memif_we, ewe); end
         a = e1 ? m1_addr[7:0] : m0_addr[7:0];
         if (e0 || e1) begin
            checks++; if (memif_addr[7:0] !== a || memif_be !== (e1 ? m1_be : m0_be)) begin errs++; $display("FAIL rnd_memif cyc=%0d addr=%h be=%h exp=%h/%h", n, memif_addr, memif_be, a, e1 ? m1_be : m0_be); end
         end
         erv0 = e0 && !m0_we;
         erv1 = e1 && !m1_we;
         erd = ref_mem[a];
         if (ewe)
            for (int b = 0; b < 4; b++)
               if (e1 ? m1_be[b] : m0_be[b]) ref_mem[a][8*b +: 8] = e1 ? m1_wdata[8*b +: 8] : m0_wdata[8*b +: 8];
         wait_obs = (m1_req && !m1_gnt) ? wait_obs + 1 : 0;
         if (wait_obs > max_wait) max_wait = wait_obs;
         d = (m1_req && !e1) ? d + 1 : 0;
         if (e1) p1 = 1'b0;
         @(posedge clk); #1;
         checks++; if (m0_rvalid !== erv0 || m1_rvalid !== erv1) begin errs++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp=%b%b", n, m0_rvalid, m1_rvalid, erv0, erv1); end
         if (erv0 || erv1) begin
            checks++; if ((erv0 ? m0_rdata : m1_rdata) !== erd) begin errs++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", n, erv0 ? m0_rdata : m1_rdata, erd); end
         end
      end
      checks++; if (max_wait > LIMIT) begin errs++; $display("FAIL rnd_max_wait got=%0d exp<=%0d", max_wait, LIMIT); end
      @(negedge clk) idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = $urandom;
         ram[i] <= ref_mem[i];
      end
      test_reset();
      test_m0_read();
      test_starvation();
      test_write_read();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
      $finish;
   end
endmodule
